// File: rtl/mac_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_frame_sequencer_pkg
//  Description : Shared definitions for the MAC frame sequencer: default
//                datapath widths and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package mac_frame_sequencer_pkg;

    // Default product / accumulator width and frame-length counter width.
    localparam int unsigned W_DEFAULT     = 8;
    localparam int unsigned CNT_W_DEFAULT = 8;

    // Frame sequencer states. Encoding is shared with the accumulator and
    // multiplier top so that state can be probed consistently.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HOLD   = 3'd4
    } seq_state_e;

endpackage : mac_frame_sequencer_pkg
`default_nettype wire

// File: rtl/mac_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_frame_sequencer_if
//  Description : Bundle of every non-clock/reset signal of the frame
//                sequencer: frame start, product stream, accumulator pins,
//                result handshake and busy status.
//  Revision    : 1.0  initial release
//
//  Signals
//    start      frame request (sampled only while idle)
//    len        number of products in the frame, sampled with start
//    prod_valid product present on prod
//    prod       product from the multiplier
//    prod_ready sequencer accepts prod this cycle
//    acc_add    accumulator input (prod on accept, otherwise zero)
//    acc_clr    accumulator synchronous clear
//    acc        accumulator output
//    res_valid  result available
//    res_ready  downstream accepts result
//    res_data   frame sum modulo 2^W
//    res_ovf    at least one carry out of W bits during the frame
//    busy       sequencer not idle
//
//  Modports
//    master  the sequencer side
//    slave   the surrounding environment (multiplier, accumulator, sink)
// ============================================================================
interface mac_frame_sequencer_if
    import mac_frame_sequencer_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

    logic             start;
    logic [CNT_W-1:0] len;
    logic             prod_valid;
    logic [W-1:0]     prod;
    logic             prod_ready;
    logic [W-1:0]     acc_add;
    logic             acc_clr;
    logic [W-1:0]     acc;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic             res_ovf;
    logic             busy;

    modport master (
        input  start, len, prod_valid, prod, acc, res_ready,
        output prod_ready, acc_add, acc_clr, res_valid, res_data, res_ovf, busy
    );

    modport slave (
        output start, len, prod_valid, prod, acc, res_ready,
        input  prod_ready, acc_add, acc_clr, res_valid, res_data, res_ovf, busy
    );

endinterface : mac_frame_sequencer_if
`default_nettype wire

// File: rtl/mac_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mac_frame_sequencer
//  Description : Sequences one frame of LEN multiplier products into an
//                external accumulator. Clears the accumulator at frame start,
//                forces its input to zero whenever no product is accepted,
//                captures the final sum with a sticky carry-out flag and
//                presents it downstream over a valid/ready handshake.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk     in  clock, all state updates on the rising edge
//    rst     in  synchronous active-high reset; also clears the accumulator
//    bus_io  --  mac_frame_sequencer_if.master (frame control, product
//                stream, accumulator pins, result handshake, busy)
// ============================================================================
module mac_frame_sequencer
    import mac_frame_sequencer_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  wire                          clk,
    input  wire                          rst,
    mac_frame_sequencer_if.master        bus_io
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] len_q,   len_d;
    logic             ovf_q,   ovf_d;
    logic             res_valid_q, res_valid_d;
    logic [W-1:0]     res_data_q,  res_data_d;
    logic             res_ovf_q,   res_ovf_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic         w_accept;
    logic         w_last;
    logic [W:0]   w_sum;
    logic         w_carry;

    // Reset aborts the frame in the same cycle, so no product may be
    // handed to the accumulator while rst is high.
    assign w_accept = (state_q == ST_RUN) && bus_io.prod_valid && !rst;
    assign w_last   = (cnt_q == (len_q - C_CNT_ONE));

    // The accumulator will compute acc + prod on this edge; the extra top
    // bit of the widened sum is the carry it is about to lose.
    assign w_sum    = {1'b0, bus_io.acc} + {1'b0, bus_io.prod};
    assign w_carry  = w_sum[W];

    // ------------------------------------------------------------------
    // Next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                // A zero-length request is dropped rather than producing
                // an empty result.
                if (bus_io.start && (bus_io.len != '0)) begin
                    len_d   = bus_io.len;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (w_accept) begin
                    cnt_d = cnt_q + C_CNT_ONE;
                    ovf_d = ovf_q | w_carry;
                    if (w_last) begin
                        state_d = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                // The last product entered the accumulator on the previous
                // edge, so acc now holds the complete frame sum.
                res_data_d  = bus_io.acc;
                res_ovf_d   = ovf_q;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end

            ST_HOLD: begin
                if (bus_io.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The accumulator adds its input every cycle, so anything other than
    // an accepted product must be presented as zero.
    assign bus_io.acc_add    = w_accept ? bus_io.prod : '0;
    assign bus_io.acc_clr    = rst || (state_q == ST_CLEAR);
    assign bus_io.prod_ready = (state_q == ST_RUN) && !rst;
    assign bus_io.res_valid  = res_valid_q;
    assign bus_io.res_data   = res_data_q;
    assign bus_io.res_ovf    = res_ovf_q;
    assign bus_io.busy       = (state_q != ST_IDLE);

endmodule : mac_frame_sequencer
`default_nettype wire

// File: tb/tb_mac_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_frame_sequencer
//  Description : Self-checking bench for mac_frame_sequencer together with a
//                behavioural accumulator. Expected sums and overflow flags are
//                taken from the integer total of each frame.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mac_frame_sequencer;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mac_frame_sequencer_if #(.W(W), .CNT_W(CNT_W)) bus ();

    mac_frame_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    // Accumulator: adds its input every cycle, synchronous clear.
    logic [W-1:0] acc_reg;
    always @(posedge clk) begin
        if (bus.acc_clr) acc_reg <= '0;
        else             acc_reg <= acc_reg + bus.acc_add;
    end
    assign bus.acc = acc_reg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Products of the frame currently being driven.
    int frame_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.prod_valid = 1'b0;
        bus.prod       = '0;
        bus.res_ready  = 1'b0;
    endtask

    // Drives one complete frame from IDLE and checks it end to end.
    // gap_mode: 0 back-to-back, 1 gap after every product, 2 random gaps.
    task automatic run_frame(input string tag, input int gap_mode, input int hold_cycles);
        int total;
        int exp_data;
        bit exp_ovf;
        logic [W-1:0] held;
        total = 0;
        foreach (frame_q[i]) total += frame_q[i];
        exp_data = total % (1 << W);
        exp_ovf  = (total >= (1 << W));

        bus.start = 1'b1;
        bus.len   = CNT_W'(frame_q.size());
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.acc_clr !== 1'b1 || bus.busy !== 1'b1 || bus.prod_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s clear_cycle: acc_clr=%b busy=%b prod_ready=%b required 1 1 0",
                     tag, bus.acc_clr, bus.busy, bus.prod_ready);
        end
        tick();
        checks++;
        if (bus.acc !== '0) begin
            failures++;
            $display("FAIL %s acc_cleared: acc=%0d required 0", tag, bus.acc);
        end

        foreach (frame_q[i]) begin
            if ((gap_mode == 2 && $urandom_range(0, 2) == 0) || (gap_mode == 1 && i != 0)) begin
                bus.prod_valid = 1'b0;
                bus.prod       = W'($urandom);
                #1;
                checks++;
                if (bus.acc_add !== '0 || bus.prod_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL %s gap_cycle: acc_add=%0d prod_ready=%b required 0 1",
                             tag, bus.acc_add, bus.prod_ready);
                end
                tick();
            end
            bus.prod_valid = 1'b1;
            bus.prod       = W'(frame_q[i]);
            #1;
            checks++;
            if (bus.acc_add !== W'(frame_q[i]) || bus.prod_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s accept_%0d: acc_add=%0d prod_ready=%b required %0d 1",
                         tag, i, bus.acc_add, bus.prod_ready, frame_q[i]);
            end
            tick();
        end
        bus.prod_valid = 1'b0;

        // One cycle after the last accept edge: sum present, result not yet.
        checks++;
        if (bus.res_valid !== 1'b0 || bus.prod_ready !== 1'b0 || bus.acc !== W'(exp_data)) begin
            failures++;
            $display("FAIL %s settle: res_valid=%b prod_ready=%b acc=%0d required 0 0 %0d",
                     tag, bus.res_valid, bus.prod_ready, bus.acc, exp_data);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== W'(exp_data) || bus.res_ovf !== exp_ovf) begin
            failures++;
            $display("FAIL %s result: valid=%b data=%0d ovf=%b required 1 %0d %b",
                     tag, bus.res_valid, bus.res_data, bus.res_ovf, exp_data, exp_ovf);
        end

        held = bus.res_data;
        for (int h = 0; h < hold_cycles; h++) begin
            // A new request while the result waits must be ignored.
            bus.start = 1'b1;
            bus.len   = CNT_W'(3);
            tick();
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== held || bus.prod_ready !== 1'b0 ||
                bus.acc_clr !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL %s hold_%0d: valid=%b data=%0d prod_ready=%b acc_clr=%b busy=%b required 1 %0d 0 0 1",
                         tag, h, bus.res_valid, bus.res_data, bus.prod_ready, bus.acc_clr, bus.busy, held);
            end
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s handshake: res_valid=%b busy=%b required 0 0",
                     tag, bus.res_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.acc_clr !== 1'b1) begin
            failures++;
            $display("FAIL reset_acc_clr: acc_clr=%b required 1", bus.acc_clr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== '0 ||
            bus.res_ovf !== 1'b0 || bus.prod_ready !== 1'b0 || bus.acc_add !== '0 ||
            bus.acc_clr !== 1'b0 || bus.acc !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b valid=%b data=%0d ovf=%b prod_ready=%b acc_add=%0d acc_clr=%b acc=%0d required all 0",
                     bus.busy, bus.res_valid, bus.res_data, bus.res_ovf, bus.prod_ready,
                     bus.acc_add, bus.acc_clr, bus.acc);
        end
    endtask

    task automatic test_basic();
        frame_q = '{2, 3, 4};
        run_frame("basic", 0, 0);
    endtask

    task automatic test_overflow();
        frame_q = '{200, 100};
        run_frame("overflow", 0, 0);
    endtask

    task automatic test_gaps();
        frame_q = '{1, 1, 1, 1};
        run_frame("gaps", 1, 0);
    endtask

    task automatic test_hold();
        frame_q = '{10, 20};
        run_frame("hold", 0, 5);
        frame_q = '{7};
        run_frame("after_hold", 0, 0);
    endtask

    task automatic test_midframe_reset();
        bus.start = 1'b1;
        bus.len   = CNT_W'(4);
        tick();
        bus.start = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.prod_valid = 1'b1;
            bus.prod       = W'(50 + i);
            tick();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.acc_clr !== 1'b1 || bus.acc_add !== '0 || bus.prod_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_cycle: acc_clr=%b acc_add=%0d prod_ready=%b required 1 0 0",
                     bus.acc_clr, bus.acc_add, bus.prod_ready);
        end
        tick();
        rst = 1'b0;
        bus.prod_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== '0 ||
            bus.res_ovf !== 1'b0 || bus.prod_ready !== 1'b0 || bus.acc !== '0) begin
            failures++;
            $display("FAIL abort_state: busy=%b valid=%b data=%0d ovf=%b prod_ready=%b acc=%0d required all 0",
                     bus.busy, bus.res_valid, bus.res_data, bus.res_ovf, bus.prod_ready, bus.acc);
        end
        frame_q = '{5};
        run_frame("after_abort", 0, 0);
    endtask

    task automatic test_zero_len();
        bus.start = 1'b1;
        bus.len   = '0;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.acc_clr !== 1'b0) begin
            failures++;
            $display("FAIL zero_len: busy=%b acc_clr=%b required 0 0", bus.busy, bus.acc_clr);
        end
        tick();
        tick();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_result: res_valid=%b busy=%b required 0 0",
                     bus.res_valid, bus.busy);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 12);
            frame_q.delete();
            for (int i = 0; i < n; i++) begin
                // Mix small and large products so some frames wrap.
                if ($urandom_range(0, 1) == 0) frame_q.push_back($urandom_range(0, 15));
                else                           frame_q.push_back($urandom_range(0, 255));
            end
            run_frame($sformatf("random_%0d", f), 2, $urandom_range(0, 3));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_overflow();
        test_gaps();
        test_hold();
        test_midframe_reset();
        test_zero_len();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mac_frame_sequencer
`default_nettype wire
